// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared state encodings, debug command codes and defaults
// for the pipeline run-control sequencer.
package pipeline_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    localparam int DRAIN_CYCLES_DEF = 4;
endpackage

// File: rtl/exec_down_counter.sv
// exec_down_counter: loadable down-counter shared by STEP and DRAIN.
// Ports: clk_i/rst_i (async active-high), load_i + load_val_i load a value,
// dec_i decrements, is_one_o flags the final counted cycle.
module exec_down_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_one_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign is_one_o = (cnt_q == W'(1));
endmodule

// File: rtl/pipeline_exec_ctrl.sv
// pipeline_exec_ctrl: run-control sequencer producing the pipeline advance
// enable and PC write enable for free-run, N-cycle step, pause and
// halt-with-drain.
// Ports: i_clk, i_reset (async active-high); i_cmd_valid/i_cmd/i_step_count
// debug command; i_hazard_stall, i_halt_fetched from hazard/fetch;
// o_step, o_pc_write enables; o_cmd_ready; o_state; o_done pulse on HALTED
// entry; o_cycle_count saturating count of advance cycles.
module pipeline_exec_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CYC_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    input  logic [CNT_W-1:0] i_step_count,
    input  logic             i_hazard_stall,
    input  logic             i_halt_fetched,
    output logic             o_step,
    output logic             o_pc_write,
    output logic             o_cmd_ready,
    output logic [2:0]       o_state,
    output logic             o_done,
    output logic [CYC_W-1:0] o_cycle_count
);
    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               ld, dec, is_one, acc;
    logic [CNT_W-1:0]   ld_val;

    exec_down_counter #(.W(CNT_W)) u_cnt (
        .clk_i      (i_clk),
        .rst_i      (i_reset),
        .load_i     (ld),
        .load_val_i (ld_val),
        .dec_i      (dec),
        .is_one_o   (is_one)
    );

    assign o_step      = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    assign o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_pc_write  = o_step && !i_hazard_stall && !i_halt_fetched && (state_q != ST_DRAIN);
    assign o_state     = state_q;
    assign o_done      = done_q;
    assign o_cycle_count = cyc_q;
    assign acc         = i_cmd_valid && o_cmd_ready;

    // A fetched HALT outranks any command in the same cycle; the command is
    // still consumed (ready is high) and simply has no effect.
    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_val  = '0;
        dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc && i_cmd == CMD_RUN) state_d = ST_RUN;
                else if (acc && i_cmd == CMD_STEP && i_step_count != '0) begin
                    state_d = ST_STEP;
                    ld      = 1'b1;
                    ld_val  = i_step_count;
                end
            end
            ST_RUN, ST_STEP: begin
                if (i_halt_fetched) begin
                    state_d = ST_DRAIN;
                    ld      = 1'b1;
                    ld_val  = CNT_W'(DRAIN_CYCLES);
                end else if (acc && i_cmd == CMD_STOP) state_d = ST_IDLE;
                else if (state_q == ST_STEP) begin
                    if (is_one) state_d = ST_IDLE;
                    else        dec     = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (is_one) state_d = ST_HALTED;
                else        dec     = 1'b1;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);
        cyc_d  = (o_step && !(&cyc_q)) ? cyc_q + CYC_W'(1) : cyc_q;
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
        end
endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
Run-control sequencer for the MIPS pipeline under the debug unit. It generates the global pipeline advance enable (step) and the PC write enable consumed by the PC register. Modes are free-run, N-cycle step, pause, and halt-with-drain on a fetched HALT instruction. It sits between the debug UART command decoder and the fetch stage/hazard unit.

Parameters:
CNT_W, 16, width of step-count command operand and internal down-counter
DRAIN_CYCLES, 4, cycles the pipeline keeps advancing after HALT is fetched (PC frozen) so older instructions retire
CYC_W, 32, width of executed-cycle counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_cmd_valid  in  1  command strobe from debug unit; consumed only when o_cmd_ready=1
i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 STOP
i_step_count  in  CNT_W  number of cycles for STEP; sampled with the command
i_hazard_stall  in  1  load-use stall from hazard unit
i_halt_fetched  in  1  instruction in fetch decodes as HALT
o_step  out  1  pipeline advance enable (drives PC i_step and all stage registers)
o_pc_write  out  1  PC write enable
o_cmd_ready  out  1  controller accepts a command this cycle
o_state  out  3  current state encoding (debug readout)
o_done  out  1  one-cycle pulse on entry to HALTED
o_cycle_count  out  CYC_W  cycles with o_step=1 since reset

Behaviour:
- States (3-bit): IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. State, counter, cycle count and o_done are registered.
- Reset (async, any time, including mid-STEP/DRAIN): state IDLE, counter 0, o_cycle_count 0, o_done 0. Resulting outputs: o_step 0, o_pc_write 0, o_cmd_ready 1, o_state 0.
- o_step = 1 in RUN, STEP, DRAIN; 0 in IDLE, HALTED. Combinational from state.
- o_pc_write = o_step & ~i_hazard_stall & ~i_halt_fetched & (state != DRAIN). The PC never advances past HALT.
- o_cmd_ready = 1 in IDLE, RUN, STEP; 0 in DRAIN, HALTED. A command is accepted when i_cmd_valid & o_cmd_ready; NOP is accepted with no effect.
- IDLE:
  - RUN -> RUN.
  - STEP with count N>0 -> STEP, counter<=N.
  - STEP with N=0 is ignored.
  - STOP is ignored.
- RUN:
  - i_halt_fetched -> DRAIN, counter<=DRAIN_CYCLES.
  - Otherwise STOP -> IDLE.
  - RUN and STEP are accepted and ignored.
- STEP: every cycle in STEP counts as one step, including stall cycles. Priority order:
  - i_halt_fetched -> DRAIN.
  - Otherwise STOP -> IDLE.
  - Otherwise counter==1 -> IDLE.
  - Otherwise counter decrements.
  - Exactly N cycles with o_step=1 per STEP N.
- DRAIN: counter decrements each cycle; when counter==1, go to HALTED next cycle. Exactly DRAIN_CYCLES cycles with o_step=1. i_halt_fetched is ignored here.
- HALTED: terminal; exits only via i_reset. o_done=1 for the single cycle after the transition.
- Simultaneous halt_fetched and STOP in RUN/STEP: halt wins, and the STOP is consumed and discarded.
- Hazard stall: o_step stays 1 (bubble propagates) and o_pc_write=0.
- o_cycle_count increments on every cycle with o_step=1 and saturates at all-ones (no wrap).
- Latency: a command accepted at edge k gives o_step=1 in the cycle following edge k.

Decomposition:
- Shared package (pipeline_pkg): state encodings, command codes (CMD_NOP/RUN/STEP/STOP), DRAIN_CYCLES default.
- One natural sub-module, exec_down_counter: loadable CNT_W down-counter with load/dec/is_one, shared by STEP and DRAIN. Everything else lives in the FSM.

Test Plan:
- Reset mid-operation: RUN running, assert i_reset asynchronously between edges -> outputs immediately step=0, pc_write=0, ready=1, state=0, cycle_count=0.
- STEP with count=5 from IDLE, no stalls -> exactly 5 cycles step=1 and pc_write=1, then state=0, cycle_count=5.
- STEP 3 with i_hazard_stall high in the 2nd cycle -> 3 step cycles, pc_write pattern 1,0,1, then IDLE.
- RUN, then i_halt_fetched at cycle 10 -> pc_write=0 that cycle, DRAIN for 4 cycles (step=1, pc_write=0), then HALTED, o_done pulses once, ready=0, commands ignored.
- RUN with STOP and i_halt_fetched in the same cycle -> DRAIN, not IDLE. Separately, STEP count=0 in IDLE -> no state change, cycle_count unchanged.
- Preload the cycle counter near all-ones (CYC_W=4 build): run 20 cycles -> o_cycle_count holds at 15.
